// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: opaque payload, valid/ready handshake with optional skid entry,
// synchronous flush, bubble zeroing and a saturating back-pressure cycle counter.
//
// state    | meaning
// ST_EMPTY | no valid entry
// ST_ONE   | main entry valid
// ST_TWO   | main and skid entries valid (SKID=1 only)
module pipe_stage_reg #(
   parameter int WIDTH           = 32,
   parameter int SKID            = 1,
   parameter int CLEAR_ON_BUBBLE = 1,
   parameter int CNT_W           = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             main_valid, skid_valid;
   logic             accept, drain;

   assign main_valid = (state_q != ST_EMPTY);
   assign skid_valid = (state_q == ST_TWO);

   // With a skid entry in_ready comes from registered state only; without it,
   // a draining stage can refill in the same cycle via out_ready.
   assign in_ready  = ((SKID != 0) ? !skid_valid : (!main_valid || out_ready)) && !flush;
   assign accept    = in_valid && in_ready;
   assign drain     = main_valid && out_ready;
   assign out_valid = main_valid;
   assign out_data  = ((CLEAR_ON_BUBBLE != 0) && !main_valid) ? '0 : main_q;
   assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d = ST_ONE;
               main_d  = in_data;
            end
         end
         ST_ONE: begin
            if (accept && (drain || (SKID == 0))) begin
               main_d = in_data;
            end else if (accept) begin
               state_d = ST_TWO;
               skid_d  = in_data;
            end else if (drain) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (drain) begin
               state_d = ST_ONE;
               main_d  = skid_q;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      // A drain in the flush cycle has already left via the handshake; everything else is squashed.
      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = '0;
         skid_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (main_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: instance a (SKID=1, CNT_W=4, bubble zeroing) and
// instance b (SKID=0, stale bubble data); queue scoreboards checked by a negedge monitor.
module tb_pipe_stage_reg;
   localparam int W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         a_reset = 1'b1, a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
   logic [W-1:0] a_in_data = '0;
   logic         a_in_ready, a_out_valid;
   logic [W-1:0] a_out_data;
   logic [1:0]   a_occ;
   logic [3:0]   a_stall;

   logic         b_reset = 1'b1, b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
   logic [W-1:0] b_in_data = '0;
   logic         b_in_ready, b_out_valid;
   logic [W-1:0] b_out_data;
   logic [1:0]   b_occ;
   logic [15:0]  b_stall;

   pipe_stage_reg #(.WIDTH(W), .SKID(1), .CLEAR_ON_BUBBLE(1), .CNT_W(4)) dut_a (
      .clk(clk), .reset(a_reset), .flush(a_flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .occupancy(a_occ), .stall_cnt(a_stall)
   );

   pipe_stage_reg #(.WIDTH(W), .SKID(0), .CLEAR_ON_BUBBLE(0), .CNT_W(16)) dut_b (
      .clk(clk), .reset(b_reset), .flush(b_flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .occupancy(b_occ), .stall_cnt(b_stall)
   );

   int           n_checks = 0;
   int           n_fail = 0;
   logic [W-1:0] qa[$];
   logic [W-1:0] qb[$];
   logic [W-1:0] exp_a, exp_b;
   bit           acc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one beat for one cycle; expected output queued only if accepted and meant to survive.
   task automatic offer(input int dut, input logic [W-1:0] d, input bit keep, output bit accepted);
      if (dut == 0) begin
         a_in_valid = 1'b1;
         a_in_data  = d;
      end else begin
         b_in_valid = 1'b1;
         b_in_data  = d;
      end
      @(negedge clk);
      accepted = (dut == 0) ? a_in_ready : b_in_ready;
      if (accepted && keep) begin
         if (dut == 0) qa.push_back(d);
         else qb.push_back(d);
      end
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (a_out_valid && a_out_ready) begin
         if (qa.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL a_unexpected_out: got 0x%0h, expected no transfer", a_out_data);
         end else begin
            exp_a = qa.pop_front();
            check("a_out_data", 32'(a_out_data), 32'(exp_a));
         end
      end
      if (b_out_valid && b_out_ready) begin
         if (qb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL b_unexpected_out: got 0x%0h, expected no transfer", b_out_data);
         end else begin
            exp_b = qb.pop_front();
            check("b_out_data", 32'(b_out_data), 32'(exp_b));
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tick();
      tick();
      a_reset = 1'b0;
      b_reset = 1'b0;
      check("a_rst_out_valid", 32'(a_out_valid), 0);
      check("a_rst_out_data", 32'(a_out_data), 0);
      check("a_rst_occ", 32'(a_occ), 0);
      check("a_rst_in_ready", 32'(a_in_ready), 1);
      check("a_rst_stall", 32'(a_stall), 0);

      // stream at full rate
      a_out_ready = 1'b1;
      offer(0, 8'h11, 1, acc); check("a_acc_11", 32'(acc), 1);
      check("a_lat_11", 32'(a_out_data), 32'h11); check("a_occ_11", 32'(a_occ), 1);
      offer(0, 8'h22, 1, acc); check("a_acc_22", 32'(acc), 1);
      check("a_lat_22", 32'(a_out_data), 32'h22); check("a_occ_22", 32'(a_occ), 1);
      offer(0, 8'h33, 1, acc); check("a_acc_33", 32'(acc), 1);
      check("a_lat_33", 32'(a_out_data), 32'h33); check("a_occ_33", 32'(a_occ), 1);
      a_in_valid = 1'b0;
      tick();
      check("a_stream_occ_end", 32'(a_occ), 0);
      check("a_bubble_zero", 32'(a_out_data), 0);
      check("a_stream_stall", 32'(a_stall), 0);

      // back-pressure into the skid entry
      a_out_ready = 1'b0;
      offer(0, 8'hA1, 1, acc); check("a_acc_a1", 32'(acc), 1);
      offer(0, 8'hA2, 1, acc); check("a_acc_a2", 32'(acc), 1);
      check("a_bp_in_ready", 32'(a_in_ready), 0);
      check("a_bp_occ", 32'(a_occ), 2);
      check("a_bp_main", 32'(a_out_data), 32'hA1);
      repeat (3) begin
         offer(0, 8'hA3, 1, acc); check("a_hold_a3", 32'(acc), 0);
      end
      a_out_ready = 1'b1;
      offer(0, 8'hA3, 1, acc); check("a_a3_blocked_two", 32'(acc), 0);
      check("a_after_drain_occ", 32'(a_occ), 1);
      offer(0, 8'hA3, 1, acc); check("a_acc_a3", 32'(acc), 1);
      a_in_valid = 1'b0;
      tick();
      check("a_bp_occ_end", 32'(a_occ), 0);
      check("a_bp_stall", 32'(a_stall), 4);
      check("a_bp_queue", 32'(qa.size()), 0);

      // flush with two held entries
      a_out_ready = 1'b0;
      offer(0, 8'hC1, 0, acc); check("a_acc_c1", 32'(acc), 1);
      offer(0, 8'hC2, 0, acc); check("a_acc_c2", 32'(acc), 1);
      a_in_data = 8'hC3;
      a_flush = 1'b1;
      #1;
      check("a_flush_in_ready", 32'(a_in_ready), 0);
      tick();
      a_flush = 1'b0;
      a_in_valid = 1'b0;
      check("a_flush_out_valid", 32'(a_out_valid), 0);
      check("a_flush_occ", 32'(a_occ), 0);
      check("a_flush_out_data", 32'(a_out_data), 0);
      offer(0, 8'h55, 1, acc); check("a_acc_55", 32'(acc), 1);
      check("a_55_valid", 32'(a_out_valid), 1);
      check("a_55_data", 32'(a_out_data), 32'h55);
      a_in_valid = 1'b0;
      a_out_ready = 1'b1;
      tick();
      check("a_flush_stall", 32'(a_stall), 6);

      // flush coinciding with drain
      a_out_ready = 1'b0;
      offer(0, 8'hB0, 1, acc); check("a_acc_b0", 32'(acc), 1);
      offer(0, 8'hB1, 0, acc); check("a_acc_b1", 32'(acc), 1);
      a_in_data = 8'hB2;
      a_flush = 1'b1;
      a_out_ready = 1'b1;
      #1;
      check("a_fd_in_ready", 32'(a_in_ready), 0);
      check("a_fd_out_valid", 32'(a_out_valid), 1);
      tick();
      a_flush = 1'b0;
      a_in_valid = 1'b0;
      check("a_fd_occ", 32'(a_occ), 0);
      check("a_fd_out_valid_after", 32'(a_out_valid), 0);
      check("a_fd_queue", 32'(qa.size()), 0);
      check("a_fd_stall", 32'(a_stall), 7);

      // counter saturation, then reset clears it
      a_out_ready = 1'b0;
      offer(0, 8'hD0, 0, acc); check("a_acc_d0", 32'(acc), 1);
      a_in_valid = 1'b0;
      repeat (7) tick();
      check("a_stall_14", 32'(a_stall), 14);
      tick();
      check("a_stall_15", 32'(a_stall), 15);
      repeat (12) tick();
      check("a_stall_sat", 32'(a_stall), 15);
      a_reset = 1'b1;
      tick();
      a_reset = 1'b0;
      check("a_rst2_stall", 32'(a_stall), 0);
      check("a_rst2_occ", 32'(a_occ), 0);
      check("a_rst2_out_valid", 32'(a_out_valid), 0);

      // single-register variant
      check("b_rst_in_ready", 32'(b_in_ready), 1);
      check("b_rst_occ", 32'(b_occ), 0);
      check("b_rst_stall", 32'(b_stall), 0);
      offer(1, 8'hA1, 1, acc); check("b_acc_a1", 32'(acc), 1);
      check("b_full_in_ready", 32'(b_in_ready), 0);
      repeat (3) begin
         offer(1, 8'hA2, 1, acc); check("b_hold_a2", 32'(acc), 0);
         check("b_occ_max1", 32'(b_occ), 1);
      end
      b_out_ready = 1'b1;
      #1;
      check("b_comb_in_ready", 32'(b_in_ready), 1);
      offer(1, 8'hA2, 1, acc); check("b_acc_a2", 32'(acc), 1);
      offer(1, 8'hA3, 1, acc); check("b_acc_a3", 32'(acc), 1);
      check("b_occ_stream", 32'(b_occ), 1);
      b_in_valid = 1'b0;
      tick();
      check("b_occ_end", 32'(b_occ), 0);
      check("b_out_valid_end", 32'(b_out_valid), 0);
      check("b_stale_data", 32'(b_out_data), 32'hA3);
      check("b_stall", 32'(b_stall), 3);
      b_in_data = 8'h77;
      b_in_valid = 1'b1;
      b_flush = 1'b1;
      #1;
      check("b_flush_in_ready", 32'(b_in_ready), 0);
      tick();
      b_flush = 1'b0;
      b_in_valid = 1'b0;
      check("b_flush_data_zero", 32'(b_out_data), 0);
      check("b_flush_occ", 32'(b_occ), 0);
      tick();
      check("b_queue_empty", 32'(qb.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register that replaces the fixed-field, stall-zeroing segment registers between pipeline stages (ID/EX, EX/MEM, MEM/WB).
- Carries an opaque WIDTH-bit payload; each instance's stage bundles its own fields into it.
- Uses a valid/ready handshake with an optional skid entry, so back-pressure does not drop or duplicate instructions.
- Adds synchronous flush for branch and exception squash, bubble zeroing, and a saturating back-pressure cycle counter for performance debug.

Parameters:
WIDTH, 32, payload width in bits (>=1)
SKID, 1, 1 = two-entry skid buffer (registered in_ready); 0 = single register (combinational in_ready)
CLEAR_ON_BUBBLE, 1, 1 = out_data forced to 0 while out_valid=0; 0 = out_data holds the last register contents
CNT_W, 16, width of stall_cnt

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous reset, active-high
flush  input  1  synchronous squash of all held entries
in_valid  input  1  upstream offers in_data
in_ready  output  1  stage can accept this cycle
in_data  input  WIDTH  upstream payload
out_valid  output  1  main entry holds a valid payload
out_ready  input  1  downstream accepts this cycle
out_data  output  WIDTH  payload of main entry
occupancy  output  2  number of valid entries (0..2; max 1 when SKID=0)
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Definitions: accept = in_valid & in_ready; drain = out_valid & out_ready. Both are evaluated on posedge clk.
- Reset (highest priority): main_valid=0, skid_valid=0, both data registers=0, stall_cnt=0.
  - Outputs after reset: out_valid=0, out_data=0, occupancy=0, in_ready=1 (when flush=0).
- Flush (second priority):
  - Next cycle: main_valid=0, skid_valid=0, occupancy=0.
  - in_ready is forced to 0 combinationally while flush=1, so no accept occurs in a flush cycle.
  - out_valid is not gated by flush. A drain coinciding with flush completes normally (that item leaves the stage); every other held item is discarded.
  - Data registers are zeroed on flush.
  - stall_cnt is unaffected by flush.
- SKID=1 (states: EMPTY, ONE = main valid, TWO = main+skid valid):
  - in_ready = !skid_valid & !flush. Depends only on registered state and flush, never on out_ready.
  - EMPTY: accept -> ONE, main<=in_data.
  - ONE:
    - accept & drain -> ONE, main<=in_data.
    - accept & !drain -> TWO, skid<=in_data.
    - drain only -> EMPTY.
    - neither -> hold.
  - TWO: drain -> ONE, main<=skid, skid_valid=0. Otherwise hold; accept is impossible because in_ready=0.
  - Ordering is strictly FIFO. The skid entry never overtakes main.
- SKID=0:
  - in_ready = (!main_valid | out_ready) & !flush. This is a combinational path from out_ready.
  - accept -> main<=in_data, main_valid=1.
  - drain & !accept -> main_valid=0.
- Latency: an item accepted at edge N is visible on out_data/out_valid after edge N (one cycle), provided the stage was empty or draining.
- Throughput: one item per cycle sustained while out_ready=1, for both SKID values.
- out_valid = main_valid; occupancy = main_valid + skid_valid.
- out_data = main data when out_valid=1. When out_valid=0: 0 if CLEAR_ON_BUBBLE=1, else stale register value.
- stall_cnt:
  - Increments by 1 each cycle in which out_valid & !out_ready & !reset.
  - Saturates at 2^CNT_W-1; no wrap.
- Payload bits are never modified, only stored and forwarded.

Test Plan:
- Reset then stream: hold reset 2 cycles, then in_valid=1 with data 0x11,0x22,0x33 on consecutive cycles, out_ready=1 -> out_data 0x11,0x22,0x33 one cycle later each; occupancy=1 throughout; stall_cnt=0.
- Back-pressure (SKID=1): send 0xA1,0xA2,0xA3 with out_ready=0 ->
  - 0xA1 sits in main; 0xA2 in skid; in_ready=0 from the cycle after 0xA2 is accepted; 0xA3 held upstream; occupancy=2.
  - Release out_ready -> outputs 0xA1,0xA2,0xA3 in order, none lost or duplicated.
- SKID=0 same stimulus -> in_ready follows out_ready combinationally; occupancy never exceeds 1; same ordered output.
- Flush with occupancy=2 and out_ready=0 -> next cycle out_valid=0, occupancy=0, out_data=0; a new item 0x55 offered the following cycle appears one cycle later.
- Flush coinciding with drain: main=0xB0, out_ready=1, flush=1 -> 0xB0 observed as transferred; skid item discarded; in-flight in_valid item not accepted (in_ready=0).
- Counter saturation with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays 15; reset -> 0.
